// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential I-memory fetch into a small PC-tagged FIFO,
// drained by decode through valid/ready; redirect flushes and restarts fetch.
module fetch_queue #(
  parameter int unsigned      ISIZE    = 16,
  parameter int unsigned      DSIZE    = 16,
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      CW       = 3,
  parameter logic [ISIZE-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ISIZE-1:0] imem_addr,
  output logic             imem_req,
  input  logic [DSIZE-1:0] imem_data,
  input  logic             redirect,
  input  logic [ISIZE-1:0] redirect_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [DSIZE-1:0] dec_instr,
  output logic [ISIZE-1:0] dec_pc,
  output logic [ISIZE-1:0] dec_pcplus1,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DSIZE-1:0] instr_mem [DEPTH];
  logic [ISIZE-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count_q;
  logic [ISIZE-1:0] fetch_pc, fetch_pc_q;
  logic             inflight;
  logic             pop, push, req;
  logic [CW:0]      credits;

  assign dec_valid = !rst && (count_q != '0);
  assign pop       = dec_valid & dec_ready;
  assign push      = inflight & !redirect & !rst;

  // Occupancy including the in-flight response, net of this cycle's pop.
  always_comb begin
    credits = {1'b0, count_q} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    req     = !rst && !redirect && (credits < (CW+1)'(DEPTH));
  end

  assign imem_req  = req;
  assign imem_addr = fetch_pc;
  assign count     = count_q;

  always_comb begin
    dec_instr   = '0;
    dec_pc      = '0;
    dec_pcplus1 = '0;
    if (dec_valid) begin
      dec_instr   = instr_mem[rd_ptr];
      dec_pc      = pc_mem[rd_ptr];
      dec_pcplus1 = pc_mem[rd_ptr] + ISIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      fetch_pc_q <= '0;
      inflight   <= 1'b0;
      count_q    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      count_q  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= req;
      if (req) begin
        fetch_pc   <= fetch_pc + ISIZE'(1);
        fetch_pc_q <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push && !redirect) begin
      instr_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]    <= fetch_pc_q;
    end
  end

endmodule
